// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow square wave in clk cycles, with loss-of-signal flag.
// Optional glitch filter on the synchronized input: define CLOCK_PERIOD_METER_GLITCH_FILTER_EN.
module clock_period_meter #(
    parameter int W       = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         timeout
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] TO_CNT  = W'(TIMEOUT);

    state_t       state;
    logic         s1, s2, s3;
    logic         lvl;
    logic         rise, fall;
    logic [W-1:0] cnt;
    logic [W-1:0] hi_lat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= lvl;
        end
    end

`ifdef CLOCK_PERIOD_METER_GLITCH_FILTER_EN
    // f follows s2 only after three consecutive disagreeing cycles.
    logic       f;
    logic [1:0] f_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f     <= 1'b0;
            f_cnt <= 2'd0;
        end else if (s2 != f) begin
            if (f_cnt == 2'd2) begin
                f     <= s2;
                f_cnt <= 2'd0;
            end else begin
                f_cnt <= f_cnt + 2'd1;
            end
        end else begin
            f_cnt <= 2'd0;
        end
    end

    assign lvl = f;
`else
    assign lvl = s2;
`endif

    assign rise = lvl & ~s3;
    assign fall = ~lvl & s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            period    <= '0;
            high_time <= '0;
            hi_lat    <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) state <= MEASURE;
                end
                MEASURE: begin
                    if (fall) hi_lat <= cnt;
                    if (rise) begin
                        period    <= cnt;
                        high_time <= hi_lat;
                        valid     <= 1'b1;
                        timeout   <= 1'b0;
                    end else if (cnt == TO_CNT) begin
                        // Outputs keep the last measurement; only the flag changes.
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter (TIMEOUT=64); honours CLOCK_PERIOD_METER_GLITCH_FILTER_EN.
module tb_clock_period_meter;

    localparam int W = 16;
`ifdef CLOCK_PERIOD_METER_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] h;
        int           cyc;
        logic         to_now;
        logic         to_prev;
    } ev_t;

    logic         clk;
    logic         reset;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;

    ev_t              ev_q[$];
    logic [2*W-1:0]   exp_q[$];
    int               cyc = 0;
    int               n_checks = 0;
    int               n_pass = 0;
    int               n_fail = 0;
    logic             prev_to = 1'b0;
    logic             prev_valid = 1'b0;
    logic             wide_seen = 1'b0;

    clock_period_meter #(.W(W), .TIMEOUT(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // event monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            ev_t e;
            e.p = period;
            e.h = high_time;
            e.cyc = cyc;
            e.to_now = timeout;
            e.to_prev = prev_to;
            ev_q.push_back(e);
        end
        if (valid === 1'b1 && prev_valid === 1'b1) wide_seen = 1'b1;
        prev_valid = valid;
        prev_to = timeout;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic level, input int n);
        sig_in = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ev_q.delete();
    endtask

    task automatic wave(input int lo, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, lo);
            drive(1'b1, hi);
        end
        drive(1'b0, lo);
    endtask

    function automatic int ev_cyc(input int i);
        return (i < ev_q.size()) ? ev_q[i].cyc : -1;
    endfunction

    // scoreboard: compare recorded events against exp_q in order
    task automatic check_events(input string tag);
        ev_t          e;
        logic [2*W-1:0] x;
        check({tag, "_count"}, ev_q.size(), exp_q.size());
        while (exp_q.size() > 0 && ev_q.size() > 0) begin
            x = exp_q.pop_front();
            e = ev_q.pop_front();
            check({tag, "_period"}, e.p, x[2*W-1:W]);
            check({tag, "_high"}, e.h, x[W-1:0]);
        end
        exp_q.delete();
        ev_q.delete();
    endtask

    initial begin
        int t_hi[4];
        int r_last;
        int t_to;

        reset = 1'b0;
        sig_in = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        @(negedge clk);
        reset = 1'b0;
        ev_q.delete();

        // 5 low / 5 high: first valid on 2nd rise, fixed latency
        drive(1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            t_hi[i] = cyc;
            drive(1'b1, 5);
            drive(1'b0, 5);
        end
        check("w10_first_lat", ev_cyc(0), t_hi[1] + LAT);
        check("w10_last_lat", ev_cyc(2), t_hi[3] + LAT);
        check("w10_spacing", ev_cyc(1) - ev_cyc(0), 10);
        check("w10_pulse_width", wide_seen, 0);
        repeat (3) exp_q.push_back({16'd10, 16'd5});
        check_events("w10");

        // 3 low / 4 high
        do_reset();
        wave(3, 4, 4);
        check("w7_spacing_a", ev_cyc(1) - ev_cyc(0), 7);
        check("w7_spacing_b", ev_cyc(2) - ev_cyc(1), 7);
        repeat (3) exp_q.push_back({16'd7, 16'd4});
        check_events("w7");

        // loss of signal after TIMEOUT cycles, then recovery
        do_reset();
        wave(5, 5, 3);
        r_last = (ev_q.size() > 0) ? ev_q[ev_q.size()-1].cyc : -1;
        check("to_before", timeout, 0);
        t_to = -1;
        for (int k = 0; k < 200; k++) begin
            if (timeout === 1'b1) begin
                t_to = cyc;
                break;
            end
            @(negedge clk);
        end
        check("to_delay", t_to, r_last + 64);
        check("to_hold_period", period, 10);
        check("to_hold_high", high_time, 5);
        ev_q.delete();
        drive(1'b1, 5);
        drive(1'b0, 5);
        check("to_one_rise_no_valid", ev_q.size(), 0);
        check("to_still_set", timeout, 1);
        drive(1'b1, 5);
        drive(1'b0, 5);
        check("to_prev_set", (ev_q.size() > 0) ? ev_q[0].to_prev : 1'bx, 1);
        check("to_clear_on_valid", (ev_q.size() > 0) ? ev_q[0].to_now : 1'bx, 0);
        exp_q.push_back({16'd10, 16'd5});
        check_events("to_restart");

        // reset in the middle of a high phase
        do_reset();
        wave(5, 5, 3);
        check("rm_pre_period", period, 10);
        drive(1'b1, 2);
        reset = 1'b1;
        #1;
        check("rm_period", period, 0);
        check("rm_high", high_time, 0);
        check("rm_valid", valid, 0);
        check("rm_timeout", timeout, 0);
        ev_q.delete();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2);
        drive(1'b0, 5);
        drive(1'b1, 5);
        drive(1'b0, 5);
        drive(1'b1, 5);
        drive(1'b0, 5);
`ifndef CLOCK_PERIOD_METER_GLITCH_FILTER_EN
        // the still-high input after reset is seen as a rise that only arms the meter
        exp_q.push_back({16'd7, 16'd2});
`endif
        exp_q.push_back({16'd10, 16'd5});
        check_events("rm");

        // period 2 (1 low / 1 high)
        do_reset();
        wave(5, 5, 3);
        check("p2_clean_count", ev_q.size(), 2);
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 1);
            drive(1'b0, 1);
        end
        drive(1'b0, 5);
`ifdef CLOCK_PERIOD_METER_GLITCH_FILTER_EN
        check("p2_filtered_count", ev_q.size(), 2);
        check("p2_filtered_timeout", timeout, 1);
`else
        check("p2_count", ev_q.size(), 52);
        check("p2_period", period, 2);
        check("p2_high", high_time, 1);
        check("p2_timeout", timeout, 0);
`endif
        ev_q.delete();

        // 2-cycle glitch inside a 20/20 wave
        do_reset();
        drive(1'b0, 20);
        drive(1'b1, 20);
        drive(1'b0, 20);
        drive(1'b1, 20);
        drive(1'b0, 9);
        drive(1'b1, 2);
        drive(1'b0, 9);
        drive(1'b1, 20);
        drive(1'b0, 20);
        drive(1'b1, 20);
        drive(1'b0, 10);
        exp_q.push_back({16'd40, 16'd20});
`ifdef CLOCK_PERIOD_METER_GLITCH_FILTER_EN
        exp_q.push_back({16'd40, 16'd20});
`else
        exp_q.push_back({16'd29, 16'd20});
        exp_q.push_back({16'd11, 16'd2});
`endif
        exp_q.push_back({16'd40, 16'd20});
        check_events("gl");
        check("final_pulse_width", wide_seen, 0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
